// File: rtl/cascade_ctrl.sv
// Cascade controller for an 8259-style interrupt controller: tracks the INTA
// pulse sequence, drives/samples the cascade bus and gates the vector byte.
module cascade_ctrl #(
  parameter int CAS_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sp_en_n,
  input  logic                  buff,
  input  logic                  buf_ms,
  input  logic                  sngl,
  input  logic                  upm,
  input  logic                  cfg_wr,
  input  logic [(1<<CAS_W)-1:0] icw3_in,
  input  logic                  int_ack_n,
  input  logic                  int_req,
  input  logic [CAS_W-1:0]      ir_level,
  input  logic [CAS_W-1:0]      cas_in,
  output logic [CAS_W-1:0]      cas_out,
  output logic                  cas_oe,
  output logic                  vec_oe,
  output logic                  en_n,
  output logic                  cl_sig,
  output logic [1:0]            pulse_idx,
  output logic                  done,
  output logic                  abort
);
  localparam int N  = 1 << CAS_W;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, P1, GAP, PV} state_t;

  state_t          state;
  logic [N-1:0]    icw3, pend_val;
  logic            pend;
  logic            ack_q, armed;
  logic            master_l, upm_l, buff_l, casc_l, match_l;
  logic [CW-1:0]   cnt;

  logic            master_now, fall, rise, casc_now, match_now, vec_now;
  logic [CAS_W-1:0] lvl_now;
  logic [1:0]      last_idx;

  // armed keeps a strobe that is already low at reset release from looking like a fall
  assign fall       = armed & ack_q & ~int_ack_n;
  assign rise       = armed & ~ack_q & int_ack_n;
  assign master_now = buff ? buf_ms : sp_en_n;
  assign lvl_now    = int_req ? ir_level : {CAS_W{1'b1}};
  assign casc_now   = master_now & ~sngl & icw3[lvl_now];
  assign match_now  = (cas_in == icw3[CAS_W-1:0]);
  assign vec_now    = master_l ? ~casc_l : match_l;
  assign last_idx   = upm_l ? 2'd1 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      icw3      <= '0;
      pend_val  <= '0;
      pend      <= 1'b0;
      ack_q     <= 1'b1;
      armed     <= 1'b0;
      master_l  <= 1'b0;
      upm_l     <= 1'b0;
      buff_l    <= 1'b0;
      casc_l    <= 1'b0;
      match_l   <= 1'b0;
      cnt       <= '0;
      cas_out   <= '0;
      cas_oe    <= 1'b0;
      vec_oe    <= 1'b0;
      en_n      <= 1'b1;
      cl_sig    <= 1'b0;
      pulse_idx <= 2'd0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      armed <= 1'b1;
      ack_q <= int_ack_n;
      done  <= 1'b0;
      abort <= 1'b0;

      // a write that lands mid-sequence is parked and applied once back in IDLE
      if (cfg_wr) begin
        if (state == IDLE) begin
          icw3 <= icw3_in;
          pend <= 1'b0;
        end else begin
          pend_val <= icw3_in;
          pend     <= 1'b1;
        end
      end else if (state == IDLE && pend) begin
        icw3 <= pend_val;
        pend <= 1'b0;
      end

      case (state)
        IDLE: if (fall) begin
          state     <= P1;
          pulse_idx <= 2'd0;
          master_l  <= master_now;
          upm_l     <= upm;
          buff_l    <= buff;
          casc_l    <= casc_now;
          match_l   <= match_now;
          cas_oe    <= casc_now;
          cas_out   <= casc_now ? lvl_now : '0;
          cl_sig    <= master_now ? casc_now : match_now;
          vec_oe    <= 1'b0;
          en_n      <= 1'b1;
        end
        P1: if (rise) begin
          state <= GAP;
          cnt   <= '0;
        end
        GAP: begin
          // a fall in the timeout cycle still wins
          if (fall) begin
            state     <= PV;
            pulse_idx <= pulse_idx + 2'd1;
            vec_oe    <= vec_now;
            en_n      <= ~(vec_now & buff_l);
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            abort     <= 1'b1;
            cas_oe    <= 1'b0;
            cas_out   <= '0;
            cl_sig    <= 1'b0;
            vec_oe    <= 1'b0;
            en_n      <= 1'b1;
            pulse_idx <= 2'd0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PV: if (rise) begin
          vec_oe <= 1'b0;
          en_n   <= 1'b1;
          if (pulse_idx == last_idx) begin
            state     <= IDLE;
            done      <= 1'b1;
            cas_oe    <= 1'b0;
            cas_out   <= '0;
            cl_sig    <= 1'b0;
            pulse_idx <= 2'd0;
          end else begin
            state <= GAP;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cascade_ctrl.sv
// Randomized bench for cascade_ctrl: INTA sequences checked per phase against
// a sequence-level model of the expected cascade/vector behaviour.
module tb_cascade_ctrl;
  localparam int CAS_W = 3;
  localparam int TMO   = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sp_en_n = 1'b1, buff = 1'b0, buf_ms = 1'b0, sngl = 1'b0, upm = 1'b1;
  logic       cfg_wr = 1'b0, int_ack_n = 1'b1, int_req = 1'b0;
  logic [7:0] icw3_in = '0;
  logic [2:0] ir_level = '0, cas_in = '0;
  logic [2:0] cas_out;
  logic       cas_oe, vec_oe, en_n, cl_sig, done, abort;
  logic [1:0] pulse_idx;

  cascade_ctrl #(.CAS_W(CAS_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sp_en_n(sp_en_n), .buff(buff), .buf_ms(buf_ms),
    .sngl(sngl), .upm(upm), .cfg_wr(cfg_wr), .icw3_in(icw3_in),
    .int_ack_n(int_ack_n), .int_req(int_req), .ir_level(ir_level), .cas_in(cas_in),
    .cas_out(cas_out), .cas_oe(cas_oe), .vec_oe(vec_oe), .en_n(en_n), .cl_sig(cl_sig),
    .pulse_idx(pulse_idx), .done(done), .abort(abort));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] m_icw3 = '0;

  // {cas_out, cas_oe, vec_oe, en_n, cl_sig, pulse_idx, done, abort}
  wire [10:0] obs = {cas_out, cas_oe, vec_oe, en_n, cl_sig, pulse_idx, done, abort};

  function automatic logic [10:0] pk(logic [2:0] co, logic oe, logic vec, logic en,
                                     logic cl, logic [1:0] idx, logic dn, logic ab);
    return {co, oe, vec, en, cl, idx, dn, ab};
  endfunction

  localparam logic [10:0] IDLE_V = 11'b000_0_0_1_0_00_0_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_idle(input logic [7:0] v);
    @(posedge clk); #1 cfg_wr = 1'b1; icw3_in = v;
    @(posedge clk); #1 cfg_wr = 1'b0;
    m_icw3 = v;
  endtask

  // One INTA sequence; gap_fix > 0 forces every high gap to that many cycles.
  task automatic run_seq(input string nm, input int gap_fix, input bit scramble, input bit mid_cfg);
    logic       master, casc, match, vslot, bufm;
    logic [2:0] lvl;
    logic [7:0] new_icw3;
    bit         got_new;
    int         np, l, h;
    master  = buff ? buf_ms : sp_en_n;
    lvl     = int_req ? ir_level : 3'b111;
    casc    = master && !sngl && m_icw3[lvl];
    match   = (cas_in == m_icw3[2:0]);
    vslot   = master ? !casc : match;
    bufm    = buff;
    np      = upm ? 2 : 3;
    got_new = 0;
    new_icw3 = m_icw3;
    for (int k = 0; k < np; k++) begin
      l = $urandom_range(1, 3);
      int_ack_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s pulse%0d", nm, k), obs,
          pk(casc ? lvl : 3'd0, casc, (k > 0) && vslot, !((k > 0) && vslot && bufm),
             master ? casc : match, 2'(k), 1'b0, 1'b0));
      if (k == 0 && scramble) begin
        sp_en_n = 1'($urandom); buf_ms = 1'($urandom); upm = 1'($urandom);
        sngl = 1'($urandom); cas_in = 3'($urandom); int_req = 1'($urandom);
        ir_level = 3'($urandom);
      end
      if (k == 0 && mid_cfg) begin
        new_icw3 = 8'($urandom); got_new = 1;
        cfg_wr = 1'b1; icw3_in = new_icw3;
        @(posedge clk); #1 cfg_wr = 1'b0;
      end
      repeat (l - 1) @(posedge clk);
      #1 int_ack_n = 1'b1;
      @(posedge clk); @(negedge clk);
      if (k == np - 1) begin
        chk({nm, " done"}, obs, pk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
        @(negedge clk);
        chk({nm, " idle"}, obs, IDLE_V);
      end else begin
        chk($sformatf("%s gap%0d", nm, k), obs,
            pk(casc ? lvl : 3'd0, casc, 1'b0, 1'b1, master ? casc : match, 2'(k), 1'b0, 1'b0));
        h = (gap_fix > 0) ? gap_fix : $urandom_range(1, TMO);
        repeat (h - 1) @(posedge clk);
      end
    end
    if (got_new) m_icw3 = new_icw3;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", obs, IDLE_V);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle", obs, IDLE_V);

    // master cascaded, 8086 mode
    cfg_idle(8'h04);
    sp_en_n = 1; buff = 0; sngl = 0; upm = 1; int_req = 1; ir_level = 3'd2;
    run_seq("m_casc", 0, 0, 0);
    // master, level not cascaded
    ir_level = 3'd5;
    run_seq("m_plain", 0, 0, 0);
    // slave matched / unmatched
    cfg_idle(8'h03);
    sp_en_n = 0; cas_in = 3'd3;
    run_seq("s_match", 0, 0, 0);
    cas_in = 3'd4;
    run_seq("s_miss", 0, 0, 0);
    // buffered master, 8080 mode, uncascaded level
    cfg_idle(8'h04);
    buff = 1; buf_ms = 1; sp_en_n = 0; upm = 0; ir_level = 3'd6;
    run_seq("buf_8080", 0, 0, 0);
    // fall coincides with timeout cycle: must still proceed
    run_seq("gap_edge", TMO, 0, 0);

    // timeout after the first pulse
    buff = 0; sp_en_n = 1; upm = 1; ir_level = 3'd2; int_req = 1;
    int_ack_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("tmo pulse0", obs, pk(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1 int_ack_n = 1'b1;
    repeat (TMO) @(posedge clk);
    @(negedge clk);
    chk("tmo before", obs, pk(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("tmo abort", obs, pk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1));
    @(negedge clk);
    chk("tmo after", obs, IDLE_V);
    run_seq("tmo fresh", 0, 0, 0);

    // reset asserted in PV with the strobe held low through release
    sp_en_n = 1; ir_level = 3'd5; upm = 1;
    int_ack_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 int_ack_n = 1'b1;
    @(posedge clk); #1 int_ack_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst pv", obs, pk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("rst async", obs, IDLE_V);
    m_icw3 = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst held low", obs, IDLE_V);
    end
    int_ack_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst release high", obs, IDLE_V);
    ir_level = 3'd2;
    run_seq("icw3 cleared", 0, 0, 0);

    // randomized sequences with mid-sequence input changes and config writes
    for (int n = 0; n < 60; n++) begin
      buff = 1'($urandom); buf_ms = 1'($urandom); sp_en_n = 1'($urandom);
      sngl = ($urandom_range(0, 3) == 0); upm = 1'($urandom);
      int_req = ($urandom_range(0, 4) != 0); ir_level = 3'($urandom);
      if ($urandom_range(0, 3) == 0) cfg_idle(8'($urandom));
      cas_in = $urandom_range(0, 1) ? m_icw3[2:0] : 3'($urandom);
      run_seq($sformatf("rnd%0d", n), 0, 1'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
